// File: rtl/dep_pkg.sv
// Shared types for the fetch queue and the dependency checker:
// opcode encodings, the decoded instruction record and the fetch state.
package dep_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_END = 4'd4;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [3:0] pc;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_DIV;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Circular FIFO of decoded instructions. Head entry is presented directly;
// a push while full is accepted only when a pop happens in the same cycle.
module instr_fifo
  import dep_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  instr_t                         push_data,
  input  logic                           pop,
  output instr_t                         head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  instr_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the head fields read as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Walks nibble-wide instruction memory, assembles {op, rd, rs1, rs2} and
// buffers decoded instructions for the dependency checker over valid/ready.
//
// state    | meaning
// ST_IDLE  | waiting for start, address parked at 0
// ST_FETCH | one nibble per cycle; slot = mem_addr[1:0]
// ST_HALT  | fetch stopped (END, illegal op, end of memory); queue drains
module instr_fetch_queue
  import dep_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [3:0]        instr_op,
  output logic [2:0]        instr_rd,
  output logic [2:0]        instr_rs1,
  output logic [2:0]        instr_rs2,
  output logic [3:0]        instr_pc,
  output logic              done,
  output logic              err
);

  fetch_state_t                 state;
  logic [3:0]                   op_q;
  logic [2:0]                   rd_q;
  logic [2:0]                   rs1_q;
  logic                         full;
  logic                         empty;
  logic                         pop;
  logic                         push;
  logic                         at_slot3;
  logic [$clog2(DEPTH+1)-1:0]   fifo_count;
  instr_t                       push_data;
  instr_t                       head;

  assign pop      = !empty && instr_ready;
  assign at_slot3 = (state == ST_FETCH) && (mem_addr[1:0] == 2'd3);
  assign push     = at_slot3 && (!full || pop);

  // rs2 is taken straight from memory so the push happens in slot 3 itself.
  assign push_data = '{op:  op_q,
                       rd:  rd_q,
                       rs1: rs1_q,
                       rs2: mem_data[2:0],
                       pc:  4'(mem_addr[ADDR_W-1:2])};

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign instr_valid = !empty;
  assign instr_op    = head.op;
  assign instr_rd    = head.rd;
  assign instr_rs1   = head.rs1;
  assign instr_rs2   = head.rs2;
  assign instr_pc    = head.pc;
  assign done        = (state == ST_HALT) && (fifo_count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      mem_addr <= '0;
      err      <= 1'b0;
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          mem_addr <= '0;
          if (start) state <= ST_FETCH;
        end
        ST_FETCH: begin
          case (mem_addr[1:0])
            2'd0: begin
              if (mem_data == OP_END) begin
                state <= ST_HALT;
              end else if (!is_alu_op(mem_data)) begin
                err   <= 1'b1;
                state <= ST_HALT;
              end else begin
                op_q     <= mem_data;
                mem_addr <= mem_addr + ADDR_W'(1);
              end
            end
            2'd1: begin
              rd_q     <= mem_data[2:0];
              mem_addr <= mem_addr + ADDR_W'(1);
            end
            2'd2: begin
              rs1_q    <= mem_data[2:0];
              mem_addr <= mem_addr + ADDR_W'(1);
            end
            default: begin
              // Last instruction slot of memory: no wrap, flag missing END.
              if (push) begin
                if (mem_addr == '1) begin
                  err   <= 1'b1;
                  state <= ST_HALT;
                end else begin
                  mem_addr <= mem_addr + ADDR_W'(1);
                end
              end
            end
          endcase
        end
        ST_HALT: begin
          if (start) begin
            err      <= 1'b0;
            mem_addr <= '0;
            state    <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: fixed programs, hand-computed
// head values and cycle numbers, pop scoreboard for ordering.
module tb_instr_fetch_queue;
  import dep_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] mem_addr;
  logic [3:0] mem_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op;
  logic [2:0] instr_rd;
  logic [2:0] instr_rs1;
  logic [2:0] instr_rs2;
  logic [3:0] instr_pc;
  logic       done;
  logic       err;

  logic [3:0]  mem [64];
  logic [16:0] got_q [$];
  logic [16:0] exp1 [4];
  logic [16:0] head;
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];
  assign head     = {instr_op, instr_rd, instr_rs1, instr_rs2, instr_pc};

  instr_fetch_queue #(.DEPTH(2), .ADDR_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rs1   (instr_rs1),
    .instr_rs2   (instr_rs2),
    .instr_pc    (instr_pc),
    .done        (done),
    .err         (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] mk(input int op, input int rd, input int rs1,
                                     input int rs2, input int pc);
    return {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 4'(pc)};
  endfunction

  // Inputs are set just after posedge; pops are recorded at negedge.
  task automatic step();
    @(negedge clk);
    if (instr_valid && instr_ready) got_q.push_back(head);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic load_prog1();
    for (int i = 0; i < 64; i++) mem[i] = 4'd0;
    {mem[0],  mem[1],  mem[2],  mem[3]}  = {4'd0, 4'd5, 4'd0, 4'd1};
    {mem[4],  mem[5],  mem[6],  mem[7]}  = {4'd2, 4'd6, 4'd2, 4'd5};
    {mem[8],  mem[9],  mem[10], mem[11]} = {4'd1, 4'd5, 4'd3, 4'd6};
    {mem[12], mem[13], mem[14], mem[15]} = {4'd3, 4'd6, 4'd5, 4'd4};
    mem[16] = 4'd4;
  endtask

  initial begin
    exp1[0] = mk(0, 5, 0, 1, 0);
    exp1[1] = mk(2, 6, 2, 5, 1);
    exp1[2] = mk(1, 5, 3, 6, 2);
    exp1[3] = mk(3, 6, 5, 4, 3);
    instr_ready = 1'b1;
    load_prog1();
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    step();
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_addr",  32'(mem_addr),    32'd0);
    check_eq("rst_done",  32'(done),        32'd0);
    check_eq("rst_err",   32'(err),         32'd0);
    check_eq("rst_head",  32'(head),        32'd0);
    check_eq("rst_state", 32'(dut.state),   32'(ST_IDLE));

    // Straight run, consumer always ready.
    rst = 1'b0;
    got_q.delete();
    for (int c = 0; c <= 22; c++) begin
      start = (c == 0);
      if (c == 1) check_eq("t1_addr_c1", 32'(mem_addr), 32'd0);
      if (c == 4) check_eq("t1_valid_c4", 32'(instr_valid), 32'd0);
      if (c == 5 || c == 9 || c == 13 || c == 17) begin
        check_eq("t1_valid", 32'(instr_valid), 32'd1);
        check_eq("t1_head",  32'(head), 32'(exp1[(c - 5) / 4]));
      end
      if (c == 18) check_eq("t1_end_addr", 32'(mem_addr), 32'd16);
      if (c == 22) begin
        check_eq("t1_done", 32'(done), 32'd1);
        check_eq("t1_err",  32'(err),  32'd0);
      end
      step();
    end
    check_eq("t1_npop", 32'(got_q.size()), 32'd4);

    // Backpressure until cycle 30.
    do_reset();
    got_q.delete();
    for (int c = 0; c <= 45; c++) begin
      start       = (c == 0);
      instr_ready = (c >= 30);
      if (c == 20 || c == 29) begin
        check_eq("t2_stall_addr", 32'(mem_addr), 32'd11);
        check_eq("t2_count",      32'(dut.u_fifo.count), 32'd2);
        check_eq("t2_head_hold",  32'(head), 32'(exp1[0]));
      end
      if (c == 45) check_eq("t2_done", 32'(done), 32'd1);
      step();
    end
    check_eq("t2_npop", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check_eq("t2_order", 32'(got_q[i]), 32'(exp1[i]));

    // Illegal opcode at address 8.
    do_reset();
    load_prog1();
    mem[8] = 4'd7;
    instr_ready = 1'b1;
    got_q.delete();
    for (int c = 0; c <= 20; c++) begin
      start = (c == 0);
      if (c == 9)  check_eq("t3_err_c9",  32'(err), 32'd0);
      if (c == 10) check_eq("t3_err_c10", 32'(err), 32'd1);
      if (c == 20) begin
        check_eq("t3_done", 32'(done), 32'd1);
        check_eq("t3_addr", 32'(mem_addr), 32'd8);
      end
      step();
    end
    check_eq("t3_npop", 32'(got_q.size()), 32'd2);
    for (int i = 0; i < 2 && i < got_q.size(); i++)
      check_eq("t3_order", 32'(got_q[i]), 32'(exp1[i]));

    // Sixteen legal instructions, no END; register nibbles carry bit 3.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      mem[4*i]     = 4'(i % 4);
      mem[4*i + 1] = 4'(8 | (i & 7));
      mem[4*i + 2] = 4'((i + 1) & 7);
      mem[4*i + 3] = 4'(15 - i);
    end
    got_q.delete();
    for (int c = 0; c <= 70; c++) begin
      start = (c == 0);
      if (c == 64) check_eq("t4_err_c64", 32'(err), 32'd0);
      if (c == 65) check_eq("t4_err_c65", 32'(err), 32'd1);
      if (c == 70) begin
        check_eq("t4_addr", 32'(mem_addr), 32'd63);
        check_eq("t4_done", 32'(done), 32'd1);
      end
      step();
    end
    check_eq("t4_npop", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      check_eq("t4_entry", 32'(got_q[i]), 32'(mk(i % 4, i & 7, (i + 1) & 7, (15 - i) & 7, i)));

    // Restart from HALT without reset.
    load_prog1();
    got_q.delete();
    for (int c = 0; c <= 8; c++) begin
      start = (c == 0);
      if (c == 1) begin
        check_eq("t6_err_clr",  32'(err),  32'd0);
        check_eq("t6_done_clr", 32'(done), 32'd0);
        check_eq("t6_addr",     32'(mem_addr), 32'd0);
      end
      if (c == 5) begin
        check_eq("t6_valid", 32'(instr_valid), 32'd1);
        check_eq("t6_head",  32'(head), 32'(exp1[0]));
      end
      step();
    end

    // Reset mid-fetch with one instruction queued.
    do_reset();
    instr_ready = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      start = (c == 0);
      if (c == 6) check_eq("t5_count_pre", 32'(dut.u_fifo.count), 32'd1);
      if (c < 6) step();
    end
    rst   = 1'b1;
    start = 1'b0;
    step();
    rst = 1'b0;
    check_eq("t5_valid", 32'(instr_valid), 32'd0);
    check_eq("t5_addr",  32'(mem_addr),    32'd0);
    check_eq("t5_state", 32'(dut.state),   32'(ST_IDLE));
    check_eq("t5_err",   32'(err),         32'd0);
    check_eq("t5_count", 32'(dut.u_fifo.count), 32'd0);
    for (int c = 0; c < 3; c++) step();
    check_eq("t5_idle_addr", 32'(mem_addr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
